// File: rtl/openhmc_top.sv
// openhmc_top: reduced single-clock openHMC link controller.
//   Link bring-up FSM: RESET -> WAIT_PHY -> TX_NULL -> TS1 -> NULL_RX -> TRET -> ACTIVE.
//   Per-lane TS1 alignment with bit-slip and optional polarity detection.
//   Flit pass-through between the AXI4-Stream user port and the PHY once ACTIVE.
// Ports:
//   clk_hmc, res_hmc (async, active-high)
//   s_axis_tx_*     : TX stream in; accepted only in ACTIVE
//   m_axis_rx_*     : RX stream out; 1-deep holding register
//   phy_*           : lane data, per-lane bit slip / polarity, PHY ready flags
//   P_RST_N, LXRXPS, LXTXPS, FERR_N : HMC sideband
//   rf_*            : register file; 0x0 status, 0x2 control
// Optional feature: define OPENHMC_RX_TOKEN_MON_EN to add a read-only RX
//   flit counter at address 0x3 (otherwise 0x3 is an invalid address).
module openhmc_top #(
   parameter int FPW                  = 2,
   parameter int DWIDTH               = FPW*128,
   parameter int LOG_NUM_LANES        = 4,
   parameter int NUM_LANES            = 2**LOG_NUM_LANES,
   parameter int NUM_DATA_BYTES       = FPW*16,
   parameter int HMC_RF_AWIDTH        = 4,
   parameter int HMC_RF_RWIDTH        = 64,
   parameter int HMC_RF_WWIDTH        = 64,
   parameter int TNULL_CYCLES         = 22,
   parameter int RX_BIT_SLIP_CNT_LOG  = 2,
   parameter int DETECT_LANE_POLARITY = 1
) (
   input  logic                      clk_hmc,
   input  logic                      res_hmc,
   input  logic                      s_axis_tx_TVALID,
   output logic                      s_axis_tx_TREADY,
   input  logic [DWIDTH-1:0]         s_axis_tx_TDATA,
   input  logic [NUM_DATA_BYTES-1:0] s_axis_tx_TUSER,
   output logic                      m_axis_rx_TVALID,
   input  logic                      m_axis_rx_TREADY,
   output logic [DWIDTH-1:0]         m_axis_rx_TDATA,
   output logic [NUM_DATA_BYTES-1:0] m_axis_rx_TUSER,
   output logic [DWIDTH-1:0]         phy_data_tx_link2phy,
   input  logic [DWIDTH-1:0]         phy_data_rx_phy2link,
   output logic [NUM_LANES-1:0]      phy_bit_slip,
   output logic [NUM_LANES-1:0]      phy_lane_polarity,
   input  logic                      phy_tx_ready,
   input  logic                      phy_rx_ready,
   output logic                      phy_init_cont_set,
   output logic                      P_RST_N,
   output logic                      LXRXPS,
   input  logic                      LXTXPS,
   input  logic                      FERR_N,
   input  logic [HMC_RF_AWIDTH-1:0]  rf_address,
   input  logic                      rf_read_en,
   input  logic                      rf_write_en,
   input  logic [HMC_RF_WWIDTH-1:0]  rf_write_data,
   output logic [HMC_RF_RWIDTH-1:0]  rf_read_data,
   output logic                      rf_access_complete,
   output logic                      rf_invalid_address
);

   typedef enum logic [2:0] {
      ST_RESET, ST_WAIT_PHY, ST_TX_NULL, ST_TS1, ST_NULL_RX, ST_TRET, ST_ACTIVE
   } state_t;

   localparam logic [HMC_RF_AWIDTH-1:0] ADDR_STATUS = 'h0;
   localparam logic [HMC_RF_AWIDTH-1:0] ADDR_CTRL   = 'h2;
   localparam logic [HMC_RF_WWIDTH-1:0] CTRL_MASK   = 'h0000_1F1F_00FF_0037;
   localparam logic [7:0] TNULL_LAST = 8'(TNULL_CYCLES - 1);
   localparam logic [RX_BIT_SLIP_CNT_LOG:0] SLIP_HOLD = {1'b1, {RX_BIT_SLIP_CNT_LOG{1'b0}}};

   // Lane-specific TS1 marker nibble.
   function automatic logic [3:0] exp_nib(input int i);
      if (i == 0)                   return 4'h3;
      else if (i == NUM_LANES - 1)  return 4'hC;
      else                          return 4'h5;
   endfunction

   function automatic logic ts1_match(input logic [15:0] w, input logic [3:0] e);
      return (w[15:8] == 8'hF0) && (w[7:4] == e);
   endfunction

   state_t                     state_q, state_d;
   logic [7:0]                 tnull_cnt_q, tnull_cnt_d;
   logic [1:0]                 zero_cnt_q, zero_cnt_d;
   logic [3:0]                 seq_q, seq_d;
   logic [NUM_LANES-1:0]       aligned_q, aligned_d, pol_q, pol_d, slip_q, slip_d;
   logic [RX_BIT_SLIP_CNT_LOG:0] hold_q [NUM_LANES];
   logic [RX_BIT_SLIP_CNT_LOG:0] hold_d [NUM_LANES];
   logic [DWIDTH-1:0]          tx_q, tx_d, rx_data_q, rx_data_d;
   logic                       rx_full_q, rx_full_d, ovf_q, ovf_d, ovf_set, rx_accept;
   logic [HMC_RF_WWIDTH-1:0]   ctrl_q, ctrl_d;
   logic [HMC_RF_RWIDTH-1:0]   rdata_q, rdata_d, status_w, sel_w;
   logic                       done_q, done_d, inv_q, inv_d, addr_ok;
   logic                       phy_ok, rx_zero, rx_pop;
   logic [15:0]                lane_w;
   logic                       unused_ok;

   assign phy_ok  = phy_tx_ready & phy_rx_ready;
   assign rx_zero = (phy_data_rx_phy2link == '0);
   assign rx_pop  = rx_full_q & m_axis_rx_TREADY;
   assign unused_ok = ^s_axis_tx_TUSER;

   // Link FSM plus its counters.
   always_comb begin
      state_d     = state_q;
      tnull_cnt_d = '0;
      zero_cnt_d  = '0;
      seq_d       = '0;
      case (state_q)
         ST_RESET:    if (ctrl_q[0]) state_d = ST_WAIT_PHY;
         ST_WAIT_PHY: if (phy_ok && ctrl_q[1]) state_d = ST_TX_NULL;
         ST_TX_NULL: begin
            tnull_cnt_d = tnull_cnt_q + 8'd1;
            if (tnull_cnt_q == TNULL_LAST) state_d = ST_TS1;
         end
         ST_TS1:      if (&aligned_q) state_d = ST_NULL_RX;
         ST_NULL_RX: if (rx_zero) begin
            zero_cnt_d = zero_cnt_q + 2'd1;
            if (zero_cnt_q == 2'd3) state_d = ST_TRET;
         end
         ST_TRET:     state_d = ST_ACTIVE;
         ST_ACTIVE:   state_d = ST_ACTIVE;
         default:     state_d = ST_RESET;
      endcase
      if (state_q != ST_RESET && !phy_ok) state_d = ST_WAIT_PHY;
      if (!ctrl_q[0]) state_d = ST_RESET;
      // TX data is registered from the next state, so seq starts at 0 on the first TS1 word.
      if (state_d == ST_TS1) seq_d = seq_q + 4'd1;
   end

   // Per-lane alignment: check, slip, then hold off before re-checking.
   always_comb begin
      aligned_d = aligned_q;
      pol_d     = pol_q;
      slip_d    = '0;
      hold_d    = hold_q;
      lane_w    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_w = phy_data_rx_phy2link[16*i +: 16];
         if (pol_q[i]) lane_w = ~lane_w;
         if (state_q == ST_RESET) begin
            aligned_d[i] = 1'b0;
            pol_d[i]     = 1'b0;
            hold_d[i]    = '0;
         end else if (state_q == ST_TS1) begin
            if (aligned_q[i]) begin
               hold_d[i] = '0;
            end else if (hold_q[i] != '0) begin
               hold_d[i] = hold_q[i] - 1'b1;
            end else if (ts1_match(lane_w, exp_nib(i))) begin
               aligned_d[i] = 1'b1;
            end else if (DETECT_LANE_POLARITY != 0 && ts1_match(~lane_w, exp_nib(i))) begin
               pol_d[i]     = ~pol_q[i];
               aligned_d[i] = 1'b1;
            end else begin
               slip_d[i] = 1'b1;
               hold_d[i] = SLIP_HOLD;
            end
         end else if (state_q != ST_NULL_RX) begin
            aligned_d[i] = 1'b0;
            hold_d[i]    = '0;
         end
      end
   end

   // TX and RX datapaths.
   always_comb begin
      tx_d = '0;
      if (state_d == ST_TS1) begin
         for (int i = 0; i < NUM_LANES; i++)
            tx_d[16*i +: 16] = {8'hF0, exp_nib(i), seq_q};
      end else if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && s_axis_tx_TVALID) begin
         tx_d = s_axis_tx_TDATA;
      end

      rx_full_d = rx_full_q;
      rx_data_d = rx_data_q;
      ovf_set   = 1'b0;
      rx_accept = 1'b0;
      if (state_q != ST_ACTIVE) begin
         rx_full_d = 1'b0;
      end else begin
         if (rx_pop) rx_full_d = 1'b0;
         if (!rx_zero) begin
            // A pop in the same cycle frees the slot for the new word.
            if (!rx_full_q || rx_pop) begin
               rx_full_d = 1'b1;
               rx_data_d = phy_data_rx_phy2link;
               rx_accept = 1'b1;
            end else begin
               ovf_set = 1'b1;
            end
         end
      end
   end

`ifdef OPENHMC_RX_TOKEN_MON_EN
   logic [31:0] tok_cnt_q, tok_cnt_d;
   assign tok_cnt_d = rx_accept ? tok_cnt_q + 32'(FPW) : tok_cnt_q;
   always_ff @(posedge clk_hmc or posedge res_hmc)
      if (res_hmc) tok_cnt_q <= '0;
      else         tok_cnt_q <= tok_cnt_d;
`else
   logic unused_accept;
   assign unused_accept = rx_accept;
`endif

   // Register file.
   always_comb begin
      status_w        = '0;
      status_w[2:0]   = state_q;
      status_w[3]     = &aligned_q;
      status_w[4]     = FERR_N;
      status_w[5]     = LXTXPS;
      status_w[6]     = ovf_q;
      status_w[31:16] = pol_q;

      addr_ok = 1'b1;
      sel_w   = '0;
      case (rf_address)
         ADDR_STATUS: sel_w = status_w;
         ADDR_CTRL:   sel_w = ctrl_q;
`ifdef OPENHMC_RX_TOKEN_MON_EN
         4'h3:        sel_w = {32'b0, tok_cnt_q};
`endif
         default:     addr_ok = 1'b0;
      endcase

      ctrl_d = ctrl_q;
      if (rf_write_en && rf_address == ADDR_CTRL) ctrl_d = rf_write_data & CTRL_MASK;
      // A set in the same cycle as a clearing read wins so no overflow is lost.
      ovf_d   = (ovf_q & ~(rf_read_en && rf_address == ADDR_STATUS)) | ovf_set;
      rdata_d = (rf_read_en && addr_ok) ? sel_w : '0;
      done_d  = rf_read_en | rf_write_en;
      inv_d   = (rf_read_en | rf_write_en) & ~addr_ok;
   end

   always_ff @(posedge clk_hmc or posedge res_hmc) begin
      if (res_hmc) begin
         state_q     <= ST_RESET;
         tnull_cnt_q <= '0;
         zero_cnt_q  <= '0;
         seq_q       <= '0;
         aligned_q   <= '0;
         pol_q       <= '0;
         slip_q      <= '0;
         for (int i = 0; i < NUM_LANES; i++) hold_q[i] <= '0;
         tx_q        <= '0;
         rx_data_q   <= '0;
         rx_full_q   <= 1'b0;
         ovf_q       <= 1'b0;
         ctrl_q      <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         inv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tnull_cnt_q <= tnull_cnt_d;
         zero_cnt_q  <= zero_cnt_d;
         seq_q       <= seq_d;
         aligned_q   <= aligned_d;
         pol_q       <= pol_d;
         slip_q      <= slip_d;
         for (int i = 0; i < NUM_LANES; i++) hold_q[i] <= hold_d[i];
         tx_q        <= tx_d;
         rx_data_q   <= rx_data_d;
         rx_full_q   <= rx_full_d;
         ovf_q       <= ovf_d;
         ctrl_q      <= ctrl_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         inv_q       <= inv_d;
      end
   end

   assign s_axis_tx_TREADY     = (state_q == ST_ACTIVE);
   assign m_axis_rx_TVALID     = rx_full_q;
   assign m_axis_rx_TDATA      = rx_data_q;
   assign m_axis_rx_TUSER      = {NUM_DATA_BYTES{rx_full_q}};
   assign phy_data_tx_link2phy = tx_q;
   assign phy_bit_slip         = slip_q;
   assign phy_lane_polarity    = pol_q;
   assign phy_init_cont_set    = ctrl_q[1];
   assign P_RST_N              = ctrl_q[0];
   assign LXRXPS               = ~ctrl_q[2];
   assign rf_read_data         = rdata_q;
   assign rf_access_complete   = done_q;
   assign rf_invalid_address   = inv_q;

endmodule

// File: tb/tb_openhmc_top.sv
// Directed bench for openhmc_top: reset values, register file, link bring-up
// (TX NULL length, TS1 pattern, bit slip, polarity), RX holding/overflow, TX pass-through.
module tb_openhmc_top;

   localparam int DW = 256;

   logic           clk_hmc = 1'b0;
   logic           res_hmc;
   logic           s_axis_tx_TVALID, s_axis_tx_TREADY;
   logic [DW-1:0]  s_axis_tx_TDATA;
   logic [31:0]    s_axis_tx_TUSER;
   logic           m_axis_rx_TVALID, m_axis_rx_TREADY;
   logic [DW-1:0]  m_axis_rx_TDATA;
   logic [31:0]    m_axis_rx_TUSER;
   logic [DW-1:0]  phy_data_tx_link2phy, phy_data_rx_phy2link;
   logic [15:0]    phy_bit_slip, phy_lane_polarity;
   logic           phy_tx_ready, phy_rx_ready, phy_init_cont_set;
   logic           P_RST_N, LXRXPS, LXTXPS, FERR_N;
   logic [3:0]     rf_address;
   logic           rf_read_en, rf_write_en;
   logic [63:0]    rf_write_data, rf_read_data;
   logic           rf_access_complete, rf_invalid_address;

   int tests = 0;
   int fails = 0;

   always #5 clk_hmc = ~clk_hmc;

   openhmc_top dut (
      .clk_hmc(clk_hmc), .res_hmc(res_hmc),
      .s_axis_tx_TVALID(s_axis_tx_TVALID), .s_axis_tx_TREADY(s_axis_tx_TREADY),
      .s_axis_tx_TDATA(s_axis_tx_TDATA), .s_axis_tx_TUSER(s_axis_tx_TUSER),
      .m_axis_rx_TVALID(m_axis_rx_TVALID), .m_axis_rx_TREADY(m_axis_rx_TREADY),
      .m_axis_rx_TDATA(m_axis_rx_TDATA), .m_axis_rx_TUSER(m_axis_rx_TUSER),
      .phy_data_tx_link2phy(phy_data_tx_link2phy), .phy_data_rx_phy2link(phy_data_rx_phy2link),
      .phy_bit_slip(phy_bit_slip), .phy_lane_polarity(phy_lane_polarity),
      .phy_tx_ready(phy_tx_ready), .phy_rx_ready(phy_rx_ready),
      .phy_init_cont_set(phy_init_cont_set), .P_RST_N(P_RST_N), .LXRXPS(LXRXPS),
      .LXTXPS(LXTXPS), .FERR_N(FERR_N),
      .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
      .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe on one negedge, sample the registered response on the next.
   task automatic rf_read(input logic [3:0] a);
      @(negedge clk_hmc);
      rf_address = a; rf_read_en = 1'b1;
      @(negedge clk_hmc);
      rf_read_en = 1'b0;
   endtask

   task automatic rf_write(input logic [3:0] a, input logic [63:0] d);
      @(negedge clk_hmc);
      rf_address = a; rf_write_data = d; rf_write_en = 1'b1;
      @(negedge clk_hmc);
      rf_write_en = 1'b0;
   endtask

   logic [DW-1:0] ts1_rx;
   logic [15:0]   exp_slip;
   int            waited;

   initial begin
      res_hmc = 1'b1;
      s_axis_tx_TVALID = 1'b0; s_axis_tx_TDATA = '0; s_axis_tx_TUSER = '0;
      m_axis_rx_TREADY = 1'b0; phy_data_rx_phy2link = '0;
      phy_tx_ready = 1'b0; phy_rx_ready = 1'b0; LXTXPS = 1'b1; FERR_N = 1'b1;
      rf_address = '0; rf_read_en = 1'b0; rf_write_en = 1'b0; rf_write_data = '0;

      // Received TS1 words: lane 0 nibble 3, lane 15 nibble C, others 5; lane 5 corrupted.
      ts1_rx = '0;
      for (int i = 0; i < 16; i++)
         ts1_rx[16*i +: 16] = (i == 0) ? 16'hF030 : (i == 15) ? 16'hF0C0 : 16'hF050;
      ts1_rx[16*5 +: 16] = 16'h1234;

      repeat (3) @(negedge clk_hmc);
      chk("rst_p_rst_n", DW'(P_RST_N), DW'(1'b0));
      chk("rst_lxrxps", DW'(LXRXPS), DW'(1'b1));
      chk("rst_tready", DW'(s_axis_tx_TREADY), DW'(1'b0));
      chk("rst_tx_data", phy_data_tx_link2phy, '0);
      chk("rst_rx_tvalid", DW'(m_axis_rx_TVALID), DW'(1'b0));
      chk("rst_slip_pol", DW'({phy_bit_slip, phy_lane_polarity}), DW'(0));
      @(negedge clk_hmc);
      res_hmc = 1'b0;

      rf_read(4'h0);
      chk("status_reset", DW'(rf_read_data), DW'(64'h30));
      chk("rd_complete", DW'(rf_access_complete), DW'(1'b1));
      chk("rd_valid_addr", DW'(rf_invalid_address), DW'(1'b0));

      phy_tx_ready = 1'b1; phy_rx_ready = 1'b1;
      phy_data_rx_phy2link = ts1_rx;
      rf_write(4'h2, 64'h1810_00FF_0031);
      chk("wr_complete", DW'(rf_access_complete), DW'(1'b1));
      chk("p_rst_n_set", DW'(P_RST_N), DW'(1'b1));
      rf_read(4'h2);
      chk("ctrl_readback", DW'(rf_read_data), DW'(64'h1810_00FF_0031));
      rf_read(4'h7);
      chk("bad_addr_flag", DW'(rf_invalid_address), DW'(1'b1));
      chk("bad_addr_data", DW'(rf_read_data), DW'(0));

      // init_cont_set: 22 cycles of TX NULL, then TS1 words with an incrementing sequence.
      rf_write(4'h2, 64'h1810_00FF_0033);
      chk("init_cont", DW'(phy_init_cont_set), DW'(1'b1));
      chk("tx_null_0", phy_data_tx_link2phy, '0);
      for (int c = 0; c < 22; c++) begin
         @(negedge clk_hmc);
         chk($sformatf("tx_null_%0d", c + 1), phy_data_tx_link2phy, '0);
      end
      // Lane 5 is checked on the first TS1 cycle after entry, then every 5 cycles.
      for (int k = 0; k < 16; k++) begin
         @(negedge clk_hmc);
         exp_slip = (k == 1 || k == 6 || k == 11) ? 16'h0020 : 16'h0000;
         chk($sformatf("ts1_lane0_%0d", k), DW'(phy_data_tx_link2phy[15:0]), DW'(16'hF030 + 16'(k)));
         chk($sformatf("ts1_lane15_%0d", k), DW'(phy_data_tx_link2phy[255:240]), DW'(16'hF0C0 + 16'(k)));
         chk($sformatf("slip_%0d", k), DW'(phy_bit_slip), DW'(exp_slip));
      end

      // Inverted TS1 on lane 5 -> polarity detection at its next check.
      phy_data_rx_phy2link[16*5 +: 16] = 16'h0FAF;
      @(negedge clk_hmc);
      chk("lane_polarity", DW'(phy_lane_polarity), DW'(16'h0020));
      chk("slip_after_pol", DW'(phy_bit_slip), DW'(0));

      // Zero words walk NULL_RX -> TRET -> ACTIVE.
      phy_data_rx_phy2link = '0;
      waited = 0;
      while (!s_axis_tx_TREADY && waited < 30) begin
         @(negedge clk_hmc);
         waited++;
      end
      chk("active_tready", DW'(s_axis_tx_TREADY), DW'(1'b1));
      rf_read(4'h0);
      chk("status_active", DW'(rf_read_data), DW'(64'h0020_0036));

      // RX hold and overflow with TREADY low.
      phy_data_rx_phy2link = DW'(8'hAB);
      @(negedge clk_hmc);
      chk("rx_tvalid", DW'(m_axis_rx_TVALID), DW'(1'b1));
      chk("rx_tdata", m_axis_rx_TDATA, DW'(8'hAB));
      chk("rx_tuser", DW'(m_axis_rx_TUSER), DW'(32'hFFFF_FFFF));
      phy_data_rx_phy2link = DW'(8'hCD);
      @(negedge clk_hmc);
      phy_data_rx_phy2link = '0;
      chk("rx_held", m_axis_rx_TDATA, DW'(8'hAB));
      rf_read(4'h0);
      chk("status_ovf", DW'(rf_read_data), DW'(64'h0020_0076));
      rf_read(4'h0);
      chk("status_ovf_clr", DW'(rf_read_data), DW'(64'h0020_0036));
      m_axis_rx_TREADY = 1'b1;
      @(negedge clk_hmc);
      chk("rx_popped", DW'(m_axis_rx_TVALID), DW'(1'b0));

      // TX pass-through.
      s_axis_tx_TVALID = 1'b1; s_axis_tx_TDATA = DW'(8'h55);
      @(negedge clk_hmc);
      chk("tx_pass", phy_data_tx_link2phy, DW'(8'h55));
      s_axis_tx_TVALID = 1'b0;
      @(negedge clk_hmc);
      chk("tx_idle", phy_data_tx_link2phy, '0);

      // PHY ready drop -> WAIT_PHY; control bit0 cleared -> RESET.
      phy_rx_ready = 1'b0;
      @(negedge clk_hmc);
      chk("drop_tready", DW'(s_axis_tx_TREADY), DW'(1'b0));
      rf_read(4'h0);
      chk("status_wait_phy", DW'(rf_read_data), DW'(64'h0020_0031));
      rf_write(4'h2, 64'h0);
      chk("p_rst_n_clr", DW'(P_RST_N), DW'(1'b0));
      repeat (3) @(negedge clk_hmc);
      rf_read(4'h0);
      chk("status_back_reset", DW'(rf_read_data), DW'(64'h30));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/openhmc_top.md
Name: openhmc_top

Overview:
Single-clock, reduced openHMC link controller between an AXI4-Stream user port and a 16-lane PHY. Contains:
- a small register file;
- an HMC link-initialisation FSM (reset, TX NULL, TS1 lane alignment, NULL/TRET, active);
- per-lane bit-slip and polarity detection;
- flit pass-through TX/RX once the link is active.

Parameters:
FPW, 2, flits per word (only 2 supported; lane word = 16 bits)
DWIDTH, FPW*128, PHY and AXI data width
LOG_NUM_LANES, 4, log2 of lane count
NUM_LANES, 2**LOG_NUM_LANES, lane count; lane i = data[16i+15:16i]
NUM_DATA_BYTES, FPW*16, TUSER width
HMC_RF_AWIDTH / HMC_RF_RWIDTH / HMC_RF_WWIDTH, 4 / 64 / 64, register file widths
TNULL_CYCLES, 22, TX NULL duration before TS1
RX_BIT_SLIP_CNT_LOG, 2, wait 2**N cycles after each slip pulse
DETECT_LANE_POLARITY, 1, enable inverted-lane detection

Ports:
clk_hmc  in  1  clock
res_hmc  in  1  reset, asynchronous, active-high
s_axis_tx_TVALID / s_axis_tx_TREADY / s_axis_tx_TDATA / s_axis_tx_TUSER  in/out/in/in  1/1/DWIDTH/NUM_DATA_BYTES  TX stream
m_axis_rx_TVALID / m_axis_rx_TREADY / m_axis_rx_TDATA / m_axis_rx_TUSER  out/in/out/out  same widths  RX stream
phy_data_tx_link2phy  out  DWIDTH  TX lane data
phy_data_rx_phy2link  in  DWIDTH  RX lane data
phy_bit_slip  out  NUM_LANES  one-cycle slip pulse per lane
phy_lane_polarity  out  NUM_LANES  lane inversion
phy_tx_ready / phy_rx_ready  in  1  PHY ready flags
phy_init_cont_set  out  1  copy of ctrl bit1
P_RST_N  out  1  HMC reset (ctrl bit0)
LXRXPS  out  1  1 unless ctrl bit2 (sleep) is set
LXTXPS / FERR_N  in  1  HMC power state / fatal error (low = error)
rf_address  in  HMC_RF_AWIDTH  register address
rf_read_en / rf_write_en  in  1  access strobes
rf_write_data  in  64  write data
rf_read_data  out  64  read data
rf_access_complete  out  1  access acknowledge
rf_invalid_address  out  1  bad-address flag

Behaviour:
- Reset: all outputs 0, except LXRXPS = 1. FSM = RESET; ctrl register = 0.
- Register file: one-cycle latency. rf_access_complete pulses 1 cycle after any strobe.
  - 0x0 status (RO): [2:0] FSM state, [3] all lanes aligned, [4] FERR_N, [5] LXTXPS, [6] rx overflow (sticky, cleared by read), [31:16] phy_lane_polarity.
  - 0x2 control (RW): [0] P_RST_N, [1] init_cont_set, [2] sleep, [4] scrambler_disable, [5] rll_enable, [23:16] rx_tokens, [36:32] irtry_to_send, [44:40] irtry_threshold.
  - Any other address: rf_invalid_address = 1, read data = 0, no write.
- FSM states and transitions:
  - RESET -> WAIT_PHY when ctrl[0] = 1.
  - WAIT_PHY -> TX_NULL when phy_tx_ready & phy_rx_ready & ctrl[1].
  - TX_NULL: counts TNULL_CYCLES, then -> TS1.
  - TS1 -> NULL_RX when all lanes are aligned.
  - NULL_RX -> TRET after 4 consecutive all-zero RX words.
  - TRET -> ACTIVE after 1 cycle.
  - ctrl[0] = 0 in any state -> RESET next cycle.
  - PHY ready deasserting outside RESET -> WAIT_PHY.
- Lane alignment in TS1, per lane i; expected nibble E = 0xC (top lane), 0x3 (lane 0), 0x5 (others):
  - aligned when word[15:8] = 0xF0 and word[7:4] = E; once aligned, stays aligned until FSM leaves TS1/NULL_RX.
  - if DETECT_LANE_POLARITY and ~word matches, set phy_lane_polarity[i] and compare ~word thereafter.
  - otherwise pulse phy_bit_slip[i] for 1 cycle, then hold off 2**RX_BIT_SLIP_CNT_LOG cycles before re-checking.
- TX data:
  - RESET/WAIT_PHY/TX_NULL/NULL_RX/TRET: all zero.
  - TS1: lane i = {8'hF0, E, seq}; seq is a 4-bit counter incrementing every cycle.
  - ACTIVE: s_axis_tx_TREADY = 1; output = TDATA registered when TVALID, else zero.
- RX data in ACTIVE:
  - a nonzero word is captured into a 1-deep register; TVALID = 1, TUSER = all ones.
  - the register holds while TREADY = 0; a new nonzero word arriving while full is dropped and sets the overflow bit.
  - all-zero words are ignored.

Optional Feature:
OPENHMC_RX_TOKEN_MON_EN:
- Defined: address 0x3 is a read-only 32-bit count of RX flits accepted in ACTIVE; it wraps and is cleared on reset.
- Undefined: 0x3 is an invalid address.

Test Plan:
- Reset asserted -> P_RST_N = 0, LXRXPS = 1, TREADY = 0, TX data = 0, status[2:0] = RESET.
- Write 0x2 = 0x181000FF0031, then read 0x2 -> returns 0x181000FF0031; P_RST_N = 1; read address 0x7 -> rf_invalid_address = 1, data 0.
- Write 0x...0033 with both PHY ready -> TX zero for 22 cycles, then lane 0 = 0xF030..0xF03F incrementing.
- RX lane 5 = 0x1234 in TS1 -> phy_bit_slip[5] pulses, then repeats every 5 cycles; RX lane 5 = 0x0FAF -> phy_lane_polarity[5] = 1.
- All lanes TS1-correct, then 5 zero words -> FSM reaches ACTIVE, TREADY = 1.
- ACTIVE: RX word 0xAB with TREADY = 0, then second word -> first word held, overflow bit set; TX TDATA = 0x55, TVALID = 1 -> phy_data_tx = 0x55 next cycle.
